// File: rtl/cpu_types_pkg.sv
// cpu_types: shared state and owner encodings for the memory arbiter.
package cpu_types;
   typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
   typedef enum logic {OWNER_FETCH, OWNER_DATA} arb_owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and load/store, data first with fetch starvation guard.
module mem_arbiter
   import cpu_types::*;
#(
   parameter int WIDTH        = 32,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [WIDTH-1:0] d_rdata,
   output logic [WIDTH-1:0] ram_a,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_wd,
   input  logic [WIDTH-1:0] ram_rd
);
   localparam int CW = $clog2(READ_LATENCY + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_INIT   = CW'(READ_LATENCY - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   arb_state_t       r_state, w_state_nx;
   arb_owner_t       r_owner;
   logic [WIDTH-1:0] r_addr, r_if_rdata, r_d_rdata;
   logic [CW-1:0]    r_cnt;
   logic [SW-1:0]    r_starve;
   logic             r_if_rvalid, r_d_rvalid;
   logic             w_fetch_wins, w_rd_gnt, w_done;
   // grants are gated by rst so every output is 0 while reset is held
   always_comb begin
      w_fetch_wins = if_req && (!d_req || r_starve == STARVE_MAX);
      if_gnt       = !rst && r_state == ARB_IDLE && w_fetch_wins;
      d_gnt        = !rst && r_state == ARB_IDLE && d_req && !w_fetch_wins;
      w_rd_gnt     = if_gnt || (d_gnt && !d_we);
      w_done       = r_state == ARB_WAIT && r_cnt == '0;
      ram_we       = d_gnt && d_we;
      ram_wd       = ram_we ? d_wdata : '0;
      ram_a        = (r_state == ARB_WAIT) ? r_addr : if_gnt ? if_addr : d_gnt ? d_addr : '0;
      w_state_nx   = w_rd_gnt ? ARB_WAIT : w_done ? ARB_IDLE : r_state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_owner     <= OWNER_FETCH;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_if_rvalid <= w_done && r_owner == OWNER_FETCH;
         r_d_rvalid  <= w_done && r_owner == OWNER_DATA;
         if (w_rd_gnt) begin
            r_addr  <= ram_a;
            r_owner <= if_gnt ? OWNER_FETCH : OWNER_DATA;
            r_cnt   <= CNT_INIT;
         end else if (r_state == ARB_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_done && r_owner == OWNER_FETCH) r_if_rdata <= ram_rd;
         if (w_done && r_owner == OWNER_DATA) r_d_rdata <= ram_rd;
         r_starve <= (if_req && !if_gnt) ? ((r_starve == STARVE_MAX) ? r_starve : r_starve + SW'(1)) : '0;
      end
   end
   assign if_rvalid = r_if_rvalid;
   assign d_rvalid  = r_d_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; dut1 uses READ_LATENCY=1, dut3 uses READ_LATENCY=3.
module tb_mem_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, ram_we;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, ram_a, ram_wd, ram_rd;
   logic        b_d_req, b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_ram_we;
   logic [31:0] b_d_addr, b_if_rdata, b_d_rdata, b_ram_a, b_ram_wd, b_ram_rd;
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] ref_mem [64];
   typedef struct {logic [31:0] data; int due;} exp_t;
   exp_t q_if[$], q_d[$], q_b[$];
   exp_t e1, e2, e3;
   int n_cmp = 0, n_bad = 0;
   mem_arbiter #(.WIDTH(32), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .ram_a(ram_a), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd));
   mem_arbiter #(.WIDTH(32), .READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
      .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(32'h0), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(1'b0),
      .d_addr(b_d_addr), .d_wdata(32'h0), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
      .d_rdata(b_d_rdata), .ram_a(b_ram_a), .ram_we(b_ram_we), .ram_wd(b_ram_wd), .ram_rd(b_ram_rd));
   assign ram_rd   = mem1[ram_a[7:2]];
   assign b_ram_rd = mem3[b_ram_a[7:2]];
   always @(posedge clk) if (ram_we) mem1[ram_a[7:2]] <= ram_wd;
   always @(posedge clk) if (b_ram_we) mem3[b_ram_a[7:2]] <= b_ram_wd;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // grants push expectations from the bench's reference memory; rvalids pop them
   always @(negedge clk) if (!rst) begin
      if (if_gnt) begin
         check("if_excl", 32'(d_gnt), 0);
         check("if_ram_a", ram_a, if_addr);
         check("if_ram_we", 32'(ram_we), 0);
         q_if.push_back('{ref_mem[if_addr[7:2]], cyc + 2});
      end
      if (d_gnt) begin
         check("d_ram_a", ram_a, d_addr);
         check("d_ram_we", 32'(ram_we), 32'(d_we));
         if (d_we) begin
            check("d_ram_wd", ram_wd, d_wdata);
            ref_mem[d_addr[7:2]] = d_wdata;
         end else q_d.push_back('{ref_mem[d_addr[7:2]], cyc + 2});
      end
      if (if_rvalid) begin
         check("if_rv_expected", 32'(q_if.size() != 0), 1);
         if (q_if.size() != 0) begin
            e1 = q_if.pop_front();
            check("if_rdata", if_rdata, e1.data);
            check("if_rv_cycle", cyc, e1.due);
         end
      end
      if (d_rvalid) begin
         check("d_rv_expected", 32'(q_d.size() != 0), 1);
         if (q_d.size() != 0) begin
            e2 = q_d.pop_front();
            check("d_rdata", d_rdata, e2.data);
            check("d_rv_cycle", cyc, e2.due);
         end
      end
   end
   always @(negedge clk) if (!rst) begin
      if (b_d_gnt) begin
         check("b_ram_a", b_ram_a, b_d_addr);
         q_b.push_back('{ref_mem[b_d_addr[7:2]], cyc + 4});
      end
      if (b_d_rvalid) begin
         check("b_rv_expected", 32'(q_b.size() != 0), 1);
         if (q_b.size() != 0) begin
            e3 = q_b.pop_front();
            check("b_rdata", b_d_rdata, e3.data);
            check("b_rv_cycle", cyc, e3.due);
         end
      end
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic req_if(input logic [31:0] a);
      int n = 0;
      if_req = 1'b1;
      if_addr = a;
      @(negedge clk);
      while (!if_gnt && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("if_gnt_seen", 32'(if_gnt), 1);
      step(1);
      if_req = 1'b0;
   endtask
   task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      d_req = 1'b1;
      d_we = we;
      d_addr = a;
      d_wdata = wd;
      @(negedge clk);
      while (!d_gnt && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("d_gnt_seen", 32'(d_gnt), 1);
      step(1);
      d_req = 1'b0;
   endtask
   task automatic check_quiet(input string tag);
      check({tag, "_if_gnt"}, 32'(if_gnt), 0);
      check({tag, "_d_gnt"}, 32'(d_gnt), 0);
      check({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
      check({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
      check({tag, "_ram_a"}, ram_a, 0);
      check({tag, "_ram_we"}, 32'(ram_we), 0);
      check({tag, "_ram_wd"}, ram_wd, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = 32'hA500_0000 + 32'(i);
         mem1[i] = ref_mem[i];
         mem3[i] = ref_mem[i];
      end
      ref_mem[4] = 32'hDEADBEEF;
      mem1[4] = 32'hDEADBEEF;
      mem3[4] = 32'hDEADBEEF;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
      b_d_req = 1'b0; b_d_addr = 32'h0;
      #3;
      check_quiet("reset");
      check("reset_if_rdata", if_rdata, 0);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      step(1);
      rst = 1'b0;
      step(1);
      req_if(32'h10);
      step(3);
      check("s1_if_rdata", if_rdata, 32'hDEADBEEF);
      req_d(1'b1, 32'h20, 32'h12345678);
      req_d(1'b0, 32'h20, 32'h0);
      step(3);
      check("s2_load", d_rdata, 32'h12345678);
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("s3_if_gnt_c%0d", c), 32'(if_gnt), 32'(c == 4));
         check($sformatf("s3_d_gnt_c%0d", c), 32'(d_gnt), 32'(c == 0 || c == 2));
         if (c == 4) check("s3_starve_full", 32'(dut1.r_starve), 4);
         step(1);
      end
      if_req = 1'b0; d_req = 1'b0;
      check("s3_starve_clear", 32'(dut1.r_starve), 0);
      step(4);
      b_d_req = 1'b1; b_d_addr = 32'h50;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check($sformatf("s4_gnt_c%0d", c), 32'(b_d_gnt), 32'(c % 4 == 0));
         check($sformatf("s4_rv_c%0d", c), 32'(b_d_rvalid), 32'(c % 4 == 0 && c > 0));
         step(1);
      end
      b_d_req = 1'b0;
      step(6);
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      check("s5_if_gnt", 32'(if_gnt), 1);
      step(1);
      if_req = 1'b0;
      #2 rst = 1'b1;
      #1 check_quiet("s5_abort");
      q_if.delete();
      step(1);
      rst = 1'b0;
      step(4);
      req_if(32'h10);
      step(3);
      check("s5_if_rdata", if_rdata, 32'hDEADBEEF);
      if_req = 1'b1; if_addr = 32'h30;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      @(negedge clk);
      check("s6_d_gnt", 32'(d_gnt), 1);
      check("s6_if_gnt0", 32'(if_gnt), 0);
      step(1);
      d_req = 1'b0;
      @(negedge clk);
      check("s6_if_gnt1", 32'(if_gnt), 0);
      check("s6_ram_a_wait", ram_a, 32'h20);
      step(1);
      if_req = 1'b0;
      @(negedge clk);
      check("s6_if_gnt2", 32'(if_gnt), 0);
      check("s6_ram_a_idle", ram_a, 0);
      step(1);
      check("s6_starve", 32'(dut1.r_starve), 0);
      step(3);
      check("end_q_if", 32'(q_if.size()), 0);
      check("end_q_d", 32'(q_d.size()), 0);
      check("end_q_b", 32'(q_b.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
